// File: rtl/bit_serial_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_pkg
// Shared definitions for the bit-serial transmitter:
//   SER_W      default operand word width
//   SER_CNT_W  bit-counter width derived from SER_W
//   state_t    transmitter state (IDLE / SHIFT)
// -----------------------------------------------------------------------------
package bit_serial_pkg;

    localparam int SER_W     = 12;
    localparam int SER_CNT_W = $clog2(SER_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serial_shreg.sv
// -----------------------------------------------------------------------------
// bit_serial_shreg
// One serial lane: a one-word holding register, a shifter and the serial
// output bit taken straight from the shifter register.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (clears the shifter)
//   load_new   in   load shifter from din
//   load_hold  in   load shifter from the holding register (wins over load_new)
//   shift      in   advance the shifter by one bit
//   hold_wr    in   capture din into the holding register
//   din        in   parallel word, W bits
//   ser        out  current serial bit
//
// Build option: BIT_SERIAL_TX_MSB_FIRST_EN selects MSB-first shifting.
// -----------------------------------------------------------------------------
module bit_serial_shreg
    import bit_serial_pkg::*;
#(
    parameter int W = SER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_new,
    input  logic         load_hold,
    input  logic         shift,
    input  logic         hold_wr,
    input  logic [W-1:0] din,
    output logic         ser
);

    logic [W-1:0] hold;
    logic [W-1:0] sh;

    // Hold contents are only meaningful while the top-level hold_full flag is
    // set, so this register needs no reset.
    always_ff @(posedge clk) begin
        if (hold_wr) begin
            hold <= din;
        end
    end

    // Zero fill on every shift means the shifter is all zeros once a word has
    // been fully emitted, so the serial output idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (load_hold) begin
            sh <= hold;
        end else if (load_new) begin
            sh <= din;
        end else if (shift) begin
`ifdef BIT_SERIAL_TX_MSB_FIRST_EN
            sh <= {sh[W-2:0], 1'b0};
`else
            sh <= {1'b0, sh[W-1:1]};
`endif
        end
    end

`ifdef BIT_SERIAL_TX_MSB_FIRST_EN
    assign ser = sh[W-1];
`else
    assign ser = sh[0];
`endif

endmodule

// File: rtl/bit_serial_tx.sv
// -----------------------------------------------------------------------------
// bit_serial_tx
// Parallel-to-serial transmitter for the bit-serial adder. Operand pairs are
// accepted over a valid/ready handshake and emitted as two synchronous serial
// streams with a qualifier and word-boundary flags. A one-word holding
// register per lane allows bubble-free back-to-back words.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   word_valid  in   operand pair present on a_in/b_in
//   word_ready  out  pair can be accepted this cycle (= !hold_full)
//   a_in        in   operand A, W bits
//   b_in        in   operand B, W bits
//   x           out  serial bit of A
//   y           out  serial bit of B
//   out_valid   out  x/y valid this cycle (adder in_valid)
//   word_start  out  x/y carry the first serial bit of a word
//   word_last   out  x/y carry the final serial bit of a word
//   busy        out  shifting or holding register full
//
// Build option: BIT_SERIAL_TX_MSB_FIRST_EN (undefined by default) sends bit
// W-1 first; the adder needs LSB-first, so leave it undefined for that use.
// -----------------------------------------------------------------------------
module bit_serial_tx
    import bit_serial_pkg::*;
#(
    parameter int W = SER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         x,
    output logic         y,
    output logic         out_valid,
    output logic         word_start,
    output logic         word_last,
    output logic         busy
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;

    logic transfer;
    logic last_bit;
    logic load_new;
    logic load_hold;
    logic hold_wr;
    logic shift;

    // Ready depends on a register only, never on word_valid.
    assign word_ready = !hold_full;
    assign transfer   = word_valid && word_ready;
    assign last_bit   = (state == SHIFT) && (cnt == CNT_LAST);

    // Next-word priority at the last-bit edge: held word first, then a word
    // arriving on this very edge. Any other transfer while shifting goes to
    // the holding register. A transfer can never coincide with hold_full, so
    // load_new and load_hold are mutually exclusive.
    assign load_hold = last_bit && hold_full;
    assign load_new  = transfer && ((state == IDLE) || last_bit);
    assign hold_wr   = transfer && (state == SHIFT) && !last_bit;
    assign shift     = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (transfer) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        cnt <= cnt + CNT_W'(1);
                        if (hold_wr) begin
                            hold_full <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                        if (hold_full) begin
                            hold_full <= 1'b0;
                        end else if (!transfer) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    hold_full <= 1'b0;
                end
            endcase
        end
    end

    // Outputs derive purely from registers; the flags are gated by out_valid
    // so they stay low while idle even though cnt rests at zero.
    assign out_valid  = (state == SHIFT);
    assign word_start = out_valid && (cnt == '0);
    assign word_last  = out_valid && (cnt == CNT_LAST);
    assign busy       = (state == SHIFT) || hold_full;

    bit_serial_shreg #(.W(W)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_new  (load_new),
        .load_hold (load_hold),
        .shift     (shift),
        .hold_wr   (hold_wr),
        .din       (a_in),
        .ser       (x)
    );

    bit_serial_shreg #(.W(W)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_new  (load_new),
        .load_hold (load_hold),
        .shift     (shift),
        .hold_wr   (hold_wr),
        .din       (b_in),
        .ser       (y)
    );

endmodule
